// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder.
// Collects the 3-byte (standard) or 4-byte (IntelliMouse) packet stream from
// the byte receiver. It keeps an absolute cursor position that is scaled by
// the sensitivity setting and clamped to the screen, then raises a one-cycle
// interrupt each time a complete packet has been applied.
module mouse_packet_decoder #(
  parameter int MAX_X   = 160,
  parameter int MAX_Y   = 120,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_error,
  input  logic       intellimouse,
  input  logic       inc_sens,
  input  logic       red_sens,
  output logic [5:0] mouse_status,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic [2:0] mouse_z,
  output logic [1:0] sensitivity,
  output logic [3:0] pkt_errors,
  output logic       send_interrupt
);

  localparam logic [20:0]        TIMER_LAST = 21'(TIMEOUT - 1);
  localparam logic [7:0]         X_RESET    = 8'(MAX_X / 2);
  localparam logic [7:0]         Y_RESET    = 8'(MAX_Y / 2);
  localparam logic [7:0]         X_TOP      = 8'(MAX_X - 1);
  localparam logic [7:0]         Y_TOP      = 8'(MAX_Y - 1);
  localparam logic signed [12:0] X_HI       = 13'(MAX_X - 1);
  localparam logic signed [12:0] Y_HI       = 13'(MAX_Y - 1);

  typedef enum logic [2:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    UPDATE
  } state_t;

  state_t      state_q, state_d;
  // Packed status: {Yovf, Xovf, Ysign, Xsign, R, L}
  logic [5:0]  pkt_status_q, pkt_status_d;
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [2:0]  z_q, z_d;
  logic        four_byte_q, four_byte_d;
  logic [20:0] timer_q, timer_d;
  logic [1:0]  sens_q, sens_d;
  logic [3:0]  pkt_errors_q, pkt_errors_d;
  logic [5:0]  status_out_q, status_out_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  mouse_z_q, mouse_z_d;
  logic        irq_q, irq_d;
  logic        drop;

  logic signed [11:0] dx_ext, dy_ext, sdx, sdy;
  logic signed [12:0] x_sum, y_sum;
  logic [7:0]         x_clamped, y_clamped;

  function automatic logic signed [11:0] scale_delta(input logic signed [11:0] d,
                                                     input logic [1:0] sens);
    case (sens)
      2'd0:    scale_delta = d >>> 1;
      2'd1:    scale_delta = d;
      2'd2:    scale_delta = d <<< 1;
      default: scale_delta = d <<< 2;
    endcase
  endfunction

  // Sign-extend, overflow-mask and scale the latched deltas, then clamp the new position
  always_comb begin
    dx_ext = pkt_status_q[4] ? 12'sd0 : {{4{pkt_status_q[2]}}, dx_q};
    dy_ext = pkt_status_q[5] ? 12'sd0 : {{4{pkt_status_q[3]}}, dy_q};
    sdx    = scale_delta(dx_ext, sens_q);
    sdy    = scale_delta(dy_ext, sens_q);
    x_sum  = $signed({5'b0, x_q}) + $signed({sdx[11], sdx});
    y_sum  = $signed({5'b0, y_q}) - $signed({sdy[11], sdy});
    if (x_sum < 13'sd0)     x_clamped = 8'd0;
    else if (x_sum > X_HI)  x_clamped = X_TOP;
    else                    x_clamped = x_sum[7:0];
    if (y_sum < 13'sd0)     y_clamped = 8'd0;
    else if (y_sum > Y_HI)  y_clamped = Y_TOP;
    else                    y_clamped = y_sum[7:0];
  end

  // Sensitivity steps every cycle; both requests at once cancel out
  always_comb begin
    sens_d = sens_q;
    if (inc_sens && !red_sens && sens_q != 2'd3) sens_d = sens_q + 2'd1;
    if (red_sens && !inc_sens && sens_q != 2'd0) sens_d = sens_q - 2'd1;
  end

  // Packet assembly FSM: byte capture, drop on error/timeout, and output update
  always_comb begin
    state_d      = state_q;
    pkt_status_d = pkt_status_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    z_d          = z_q;
    four_byte_d  = four_byte_q;
    timer_d      = timer_q;
    pkt_errors_d = pkt_errors_q;
    status_out_d = status_out_q;
    x_d          = x_q;
    y_d          = y_q;
    mouse_z_d    = mouse_z_q;
    irq_d        = 1'b0;
    drop         = 1'b0;
    case (state_q)
      WAIT_B0, UPDATE: begin
        timer_d = '0;
        if (state_q == UPDATE) begin
          status_out_d = pkt_status_q;
          x_d          = x_clamped;
          y_d          = y_clamped;
          mouse_z_d    = four_byte_q ? z_q : 3'd0;
          irq_d        = 1'b1;
          state_d      = WAIT_B0;
        end
        // A byte without bit3 set cannot be a status byte, so it is skipped to resync
        if (byte_valid && byte_in[3]) begin
          pkt_status_d = {byte_in[7:4], byte_in[1:0]};
          four_byte_d  = intellimouse;
          state_d      = WAIT_B1;
        end
      end
      WAIT_B1, WAIT_B2, WAIT_B3: begin
        if (byte_error) begin
          drop = 1'b1;
        end else if (byte_valid) begin
          timer_d = '0;
          case (state_q)
            WAIT_B1: begin
              dx_d    = byte_in;
              state_d = WAIT_B2;
            end
            WAIT_B2: begin
              dy_d    = byte_in;
              state_d = four_byte_q ? WAIT_B3 : UPDATE;
            end
            default: begin
              z_d     = byte_in[2:0];
              state_d = UPDATE;
            end
          endcase
        end else if (timer_q == TIMER_LAST) begin
          drop = 1'b1;
        end else begin
          timer_d = timer_q + 21'd1;
        end
        if (drop) begin
          state_d = WAIT_B0;
          timer_d = '0;
          if (pkt_errors_q != 4'hF) pkt_errors_d = pkt_errors_q + 4'd1;
        end
      end
      default: state_d = WAIT_B0;
    endcase
  end

  // State and output registers; reset abandons any partial packet at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_B0;
      pkt_status_q <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      z_q          <= '0;
      four_byte_q  <= 1'b0;
      timer_q      <= '0;
      sens_q       <= 2'd1;
      pkt_errors_q <= '0;
      status_out_q <= '0;
      x_q          <= X_RESET;
      y_q          <= Y_RESET;
      mouse_z_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_status_q <= pkt_status_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      z_q          <= z_d;
      four_byte_q  <= four_byte_d;
      timer_q      <= timer_d;
      sens_q       <= sens_d;
      pkt_errors_q <= pkt_errors_d;
      status_out_q <= status_out_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mouse_z_q    <= mouse_z_d;
      irq_q        <= irq_d;
    end
  end

  assign mouse_status   = status_out_q;
  assign mouse_x        = x_q;
  assign mouse_y        = y_q;
  assign mouse_z        = mouse_z_q;
  assign sensitivity    = sens_q;
  assign pkt_errors     = pkt_errors_q;
  assign send_interrupt = irq_q;

endmodule

// File: doc/mouse_packet_decoder.md
# mouse_packet_decoder

Assembles the PS/2 mouse byte stream into 3-byte (standard) or 4-byte (IntelliMouse) packets, then tracks an absolute, clamped, sensitivity-scaled cursor position. It sits between the PS/2 byte receiver and the memory-mapped mouse IO peripheral. It feeds that peripheral's status, X, Y, Z and sensitivity registers, and its interrupt-raise input.

## Interface

- MAX_X, 160: X range; position is clamped to 0..MAX_X-1.
- MAX_Y, 120: Y range; position is clamped to 0..MAX_Y-1.
- TIMEOUT, 2_000_000: maximum idle cycles between bytes of one packet before the partial packet is dropped.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BYTE_IN  in  8  received byte; valid only while BYTE_VALID is high.
- BYTE_VALID  in  1  one-cycle strobe: BYTE_IN holds a good byte.
- BYTE_ERROR  in  1  one-cycle strobe: receiver framing or parity error.
- INTELLIMOUSE  in  1  1 selects 4-byte packets; sampled when byte 0 is accepted.
- INC_SENS  in  1  sensitivity increment request.
- RED_SENS  in  1  sensitivity decrement request.
- MOUSE_STATUS  out  6  {Yovf, Xovf, Ysign, Xsign, R, L} from the last packet.
- MOUSE_X  out  8  absolute X position.
- MOUSE_Y  out  8  absolute Y position.
- MOUSE_Z  out  3  byte3[2:0] of the last 4-byte packet; 0 in 3-byte mode.
- SENSITIVITY  out  2  current sensitivity, 0..3.
- PKT_ERRORS  out  4  dropped-packet count; saturates at 15.
- SEND_INTERRUPT  out  1  one-cycle pulse per decoded packet.

## Operation

- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, WAIT_B3, UPDATE.
- WAIT_B0:
  - A BYTE_VALID byte with bit3 = 1 is latched as status; go to WAIT_B1 and latch the 4-byte mode from INTELLIMOUSE.
  - A byte with bit3 = 0 is discarded (resync). State stays WAIT_B0; no error is counted.
- WAIT_B1: latch the dx byte, go to WAIT_B2.
- WAIT_B2: latch the dy byte, then go to WAIT_B3 in 4-byte mode or UPDATE otherwise.
- WAIT_B3: latch the z byte, go to UPDATE.
- UPDATE lasts exactly one cycle, then returns to WAIT_B0.
  - A BYTE_VALID in UPDATE is handled as a WAIT_B0 byte.
- Error drop, from WAIT_B1/B2/B3:
  - Trigger: BYTE_ERROR, or TIMEOUT cycles elapse with no BYTE_VALID.
  - Action: return to WAIT_B0 and increment PKT_ERRORS (saturating). No output changes.
  - BYTE_ERROR in WAIT_B0 is ignored.
- The timeout counter is 21 bits. It clears on each accepted byte and runs only in WAIT_B1, WAIT_B2 and WAIT_B3.
- Delta arithmetic:
  - dx is 9-bit signed {status[4], dx_byte}; dy is {status[5], dy_byte}.
  - If the matching overflow bit (status[6] for dx, status[7] for dy) is set, that delta is forced to 0.
  - Scaling, sign-extended to 12 bits: SENS 0 gives d>>>1, 1 gives d, 2 gives d<<1, 3 gives d<<2.
- Position update:
  - X_new = clamp(X + sdx, 0, MAX_X-1).
  - Y_new = clamp(Y - sdy, 0, MAX_Y-1); PS/2 up is screen up.
  - Both are computed in 13-bit signed arithmetic, so no wrap is possible.
- Sensitivity is updated every cycle, independent of the FSM:
  - INC_SENS alone: +1, saturating at 3.
  - RED_SENS alone: -1, saturating at 0.
  - Both high together: no change.
  - The value used by UPDATE is the value registered at the start of that cycle.

## Timing

- Reset values:
  - FSM in WAIT_B0.
  - MOUSE_X = MAX_X/2, MOUSE_Y = MAX_Y/2.
  - MOUSE_STATUS = 0, MOUSE_Z = 0, PKT_ERRORS = 0, SENSITIVITY = 1, SEND_INTERRUPT = 0, timeout counter = 0.
- Reset asserted mid-packet discards the partial packet immediately, without waiting for a clock edge.
- Edge E samples the final byte and the FSM enters UPDATE. At edge E+1:
  - MOUSE_STATUS, MOUSE_X, MOUSE_Y and MOUSE_Z take their new values together.
  - SEND_INTERRUPT goes high for exactly one cycle.
- Latency: 2 edges from the final byte to outputs valid.
- All outputs are registered. Outputs hold their values between packets.
- Back-to-back bytes on consecutive cycles are accepted; there is no backpressure.

## Test plan

- Reset: deassert RESET (MAX_X 160, MAX_Y 120) -> X = 80, Y = 60, STATUS = 0, SENS = 1, PKT_ERRORS = 0, SEND_INTERRUPT = 0.
- Basic packet: bytes 0x09, 0x05, 0x03 on consecutive cycles -> two edges after 0x03: STATUS = 0x01, X = 85, Y = 57, exactly one SEND_INTERRUPT pulse.
- Clamping: from X = 80, packet 0x18, 0x00, 0x00 (dx = -256) -> X = 0. Then pulse INC_SENS twice (SENS = 3) and send 0x08, 0x7F, 0x00 (sdx = 508) -> X = 159. Pulse INC_SENS again -> SENS stays 3.
- Resync and timeout:
  - Stray 0x05, then 0x08, 0x02, 0x00 -> X += 2, no error counted.
  - 0x08, 0x10, then TIMEOUT+1 idle cycles -> PKT_ERRORS = 1, no pulse.
  - Next 0x08, 0x02, 0x00 decodes normally (X += 2).
- IntelliMouse and error:
  - INTELLIMOUSE = 1, bytes 0x08, 0x00, 0x00, 0x0F -> MOUSE_Z = 7, pulse only after the 4th byte.
  - 0x08, 0x01 followed by BYTE_ERROR -> PKT_ERRORS increments, X unchanged.
- Overflow and async reset:
  - Packet 0x48, 0xFF, 0x04 -> X unchanged (dx overflow), Y -= 4.
  - Assert RESET between byte 1 and byte 2 -> outputs return to reset values before the next CLK edge. The following full packet decodes from WAIT_B0.
